miter_vector_sequencer: RTL and testbench

Exhaustive equivalence-check sequencer for a pair of 12-input / 4-output combinational circuits under comparison. It drives every input vector 0x000..0xFFF into both circuits from one shared registered vector bus, waits a configurable settle time, compares the two output words, and records the mismatch count and the first failing vector. It sits between the bench/host control interface and the two combinational netlists, which it owns and sequences.

---
 rtl/miter_vector_sequencer.sv | 132 +++++++++++++
 tb/tb_miter_vector_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/miter_vector_sequencer.sv
// Exhaustive equivalence-check sequencer: walks every input vector through
// two combinational circuits, compares their outputs after a settle delay and
// records the mismatch count plus the first failing vector and its diff.
module miter_vector_sequencer #(
    parameter int IN_W   = 12,
    parameter int OUT_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             stop_on_fail,
    output logic [IN_W-1:0]  vec_o,
    input  logic [OUT_W-1:0] out_a_i,
    input  logic [OUT_W-1:0] out_b_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IN_W:0]    mismatch_cnt,
    output logic [IN_W-1:0]  fail_vec,
    output logic [OUT_W-1:0] fail_diff
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Settle counter is 4 bits: SETTLE is limited to 1..15.
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       settle_cnt;
    logic             stop_lat;
    logic [OUT_W-1:0] diff;
    logic             mismatch;
    logic             last_vec;

    assign diff     = out_a_i ^ out_b_i;
    assign mismatch = |diff;
    assign last_vec = &vec_o;

    // busy/done come straight from the state register, so they can never
    // both be high and are both low only in IDLE.
    assign busy = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done = (state_q == ST_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort only matters while a run is active.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)                 state_d = ST_IDLE;
                else if (settle_cnt == 4'd1) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (abort)                      state_d = ST_IDLE;
                else if (mismatch && stop_lat)  state_d = ST_DONE;
                else if (last_vec)              state_d = ST_DONE;
                else                            state_d = ST_SETTLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Vector bus, settle counter and result capture; all frozen on abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_o        <= '0;
            mismatch_cnt <= '0;
            fail_vec     <= '0;
            fail_diff    <= '0;
            pass         <= 1'b0;
            stop_lat     <= 1'b0;
            settle_cnt   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_o        <= '0;
                        mismatch_cnt <= '0;
                        fail_vec     <= '0;
                        fail_diff    <= '0;
                        pass         <= 1'b0;
                        stop_lat     <= stop_on_fail;
                        settle_cnt   <= SETTLE_LD;
                    end
                end
                ST_SETTLE: begin
                    if (!abort) settle_cnt <= settle_cnt - 4'd1;
                end
                ST_CHECK: begin
                    if (!abort) begin
                        if (mismatch) begin
                            mismatch_cnt <= mismatch_cnt + {{IN_W{1'b0}}, 1'b1};
                            if (mismatch_cnt == '0) begin
                                fail_vec  <= vec_o;
                                fail_diff <= diff;
                            end
                        end
                        if (state_d == ST_SETTLE) begin
                            vec_o      <= vec_o + {{(IN_W-1){1'b0}}, 1'b1};
                            settle_cnt <= SETTLE_LD;
                        end
                        // Final verdict includes this cycle's comparison.
                        if (state_d == ST_DONE) begin
                            pass <= !mismatch && (mismatch_cnt == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_miter_vector_sequencer.sv
// Directed bench for miter_vector_sequencer: table of full runs plus
// hand-written abort, ignored-start and mid-run reset sequences.
module tb_miter_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start2, abort, stop_on_fail;
    logic [11:0] vec1, vec2;
    logic [3:0]  out_a1, out_b1, out_a2, out_b2;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [12:0] cnt1, cnt2;
    logic [11:0] fv1, fv2;
    logic [3:0]  fd1, fd2;
    int          mode;
    int          checks = 0;
    int          errors = 0;

    // sampled view of the selected DUT
    logic [11:0] s_vec, s_fv;
    logic [12:0] s_cnt;
    logic [3:0]  s_fd;
    logic        s_busy, s_done, s_pass;

    always #5 clk = ~clk;

    // reference circuit and injected faults for circuit B
    function automatic logic [3:0] f_ref(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

    function automatic logic [3:0] f_err(input logic [11:0] v, input int m);
        logic [3:0] d;
        d = 4'b0000;
        if (m == 1 && v == 12'h0A5) d = 4'b0100;
        if (m == 1 && v == 12'h800) d = 4'b0011;
        if (m == 2 && v == 12'hFFF) d = 4'b1000;
        return d;
    endfunction

    assign out_a1 = f_ref(vec1);
    assign out_b1 = f_ref(vec1) ^ f_err(vec1, mode);
    assign out_a2 = f_ref(vec2);
    assign out_b2 = f_ref(vec2) ^ f_err(vec2, mode);

    miter_vector_sequencer #(.IN_W(12), .OUT_W(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
        .stop_on_fail(stop_on_fail), .vec_o(vec1), .out_a_i(out_a1),
        .out_b_i(out_b1), .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_cnt(cnt1), .fail_vec(fv1), .fail_diff(fd1)
    );

    miter_vector_sequencer #(.IN_W(12), .OUT_W(4), .SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
        .stop_on_fail(stop_on_fail), .vec_o(vec2), .out_a_i(out_a2),
        .out_b_i(out_b2), .busy(busy2), .done(done2), .pass(pass2),
        .mismatch_cnt(cnt2), .fail_vec(fv2), .fail_diff(fd2)
    );

    typedef struct {
        bit s2;        // run on the SETTLE=2 instance
        bit stop;
        int mode;
        bit with_abort; // abort raised together with start
        int cycles;
        int cnt;
        int fv;
        int fd;
        bit pass;
        int vec;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic samp(input bit s2);
        s_vec  = s2 ? vec2  : vec1;
        s_fv   = s2 ? fv2   : fv1;
        s_cnt  = s2 ? cnt2  : cnt1;
        s_fd   = s2 ? fd2   : fd1;
        s_busy = s2 ? busy2 : busy1;
        s_done = s2 ? done2 : done1;
        s_pass = s2 ? pass2 : pass1;
    endtask

    task automatic check_reset_vals(input string tag);
        samp(1'b0);
        check({tag, "_busy"}, 32'(s_busy), 0);
        check({tag, "_done"}, 32'(s_done), 0);
        check({tag, "_pass"}, 32'(s_pass), 0);
        check({tag, "_vec"},  32'(s_vec), 0);
        check({tag, "_cnt"},  32'(s_cnt), 0);
        check({tag, "_fv"},   32'(s_fv), 0);
        check({tag, "_fd"},   32'(s_fd), 0);
    endtask

    // start a run on dut1 and wait for the start edge
    task automatic start_dut1(input int m, input bit stop);
        @(negedge clk);
        mode = m; stop_on_fail = stop; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    // wait (bounded) until dut1 shows vector v, sampled on the falling edge
    task automatic wait_vec(input logic [11:0] v, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (vec1 == v) found = 1'b1;
        end
        check("wait_vec", 32'(found), 1);
    endtask

    task automatic run_entry(input vec_t e, input int idx);
        int  n;
        bit  got;
        bit  overlap;
        string t;
        t = $sformatf("run%0d", idx);
        @(negedge clk);
        mode = e.mode; stop_on_fail = e.stop; abort = e.with_abort;
        if (e.s2) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0; abort = 1'b0;
        samp(e.s2);
        check({t, "_busy_at_start"}, 32'(s_busy), 1);
        check({t, "_done_at_start"}, 32'(s_done), 0);
        check({t, "_vec_at_start"},  32'(s_vec), 0);
        got = 1'b0; overlap = 1'b0; n = 0;
        while (!got && n < e.cycles + 50) begin
            @(posedge clk); #1;
            n++;
            samp(e.s2);
            if (s_busy && s_done) overlap = 1'b1;
            if (s_done) got = 1'b1;
        end
        check({t, "_done_seen"}, 32'(got), 1);
        check({t, "_latency"},   32'(n), 32'(e.cycles));
        check({t, "_busy_done_excl"}, 32'(overlap), 0);
        check({t, "_busy_end"},  32'(s_busy), 0);
        check({t, "_pass"},      32'(s_pass), 32'(e.pass));
        check({t, "_cnt"},       32'(s_cnt), 32'(e.cnt));
        check({t, "_fail_vec"},  32'(s_fv), 32'(e.fv));
        check({t, "_fail_diff"}, 32'(s_fd), 32'(e.fd));
        check({t, "_vec_end"},   32'(s_vec), 32'(e.vec));
        repeat (3) @(posedge clk);
        #1;
        samp(e.s2);
        check({t, "_done_held"}, 32'(s_done), 1);
        check({t, "_vec_held"},  32'(s_vec), 32'(e.vec));
        check({t, "_cnt_held"},  32'(s_cnt), 32'(e.cnt));
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 0, 1'b0, 12288, 0, 0,     0, 1'b1, 'hFFF};
        tbl[1] = '{1'b0, 1'b0, 1, 1'b0, 8192,  2, 'h0A5, 4, 1'b0, 'hFFF};
        tbl[2] = '{1'b0, 1'b1, 1, 1'b0, 332,   1, 'h0A5, 4, 1'b0, 'h0A5};
        tbl[3] = '{1'b0, 1'b0, 2, 1'b1, 8192,  1, 'hFFF, 8, 1'b0, 'hFFF};

        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; abort = 1'b0;
        stop_on_fail = 1'b0; mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // start while busy is ignored, then abort during SETTLE of 0x064
        start_dut1(1, 1'b0);
        wait_vec(12'h010, 100);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        check("ignored_start_vec", 32'(vec1 >= 12'h010), 1);
        check("ignored_start_busy", 32'(busy1), 1);
        wait_vec(12'h064, 400);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy1), 0);
        check("abort_done", 32'(done1), 0);
        check("abort_cnt",  32'(cnt1), 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_idle_busy", 32'(busy1 | done1), 0);

        // restart from IDLE, then abort in the CHECK cycle of the failing vector
        start_dut1(1, 1'b0);
        check("restart_vec",  32'(vec1), 0);
        check("restart_busy", 32'(busy1), 1);
        wait_vec(12'h0A5, 600);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_chk_cnt",  32'(cnt1), 0);
        check("abort_chk_fv",   32'(fv1), 0);
        check("abort_chk_busy", 32'(busy1), 0);
        check("abort_chk_done", 32'(done1), 0);

        // one-cycle reset mid-run after a mismatch has been recorded
        start_dut1(1, 1'b0);
        wait_vec(12'h300, 2000);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // full runs
        for (int i = 0; i < 4; i++) begin
            run_entry(tbl[i], i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
